// File: rtl/debug_step_controller.sv
// Host debug sequencer in front of the instruction phase decoder: halt/run control,
// N-step and debug-step handshakes, PC breakpoint and ACK timeout guard.
module debug_step_controller #(
  parameter int PC_WIDTH     = 16,
  parameter int COUNT_WIDTH  = 16,
  parameter int ACK_TIMEOUT  = 64,
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   host_cmd_valid_i,
  input  logic [2:0]             host_cmd_i,
  input  logic [COUNT_WIDTH-1:0] host_count_i,
  output logic                   host_cmd_ready_o,
  output logic                   cmd_err_o,
  input  logic [PC_WIDTH-1:0]    pc_i,
  input  logic [PC_WIDTH-1:0]    bp_addr_i,
  input  logic                   bp_en_i,
  input  logic                   fetch_i,
  input  logic                   stopped_i,
  input  logic                   debug_step_ack_i,
  output logic                   debug_stop_o,
  output logic                   debug_mode_o,
  output logic                   debug_step_req_o,
  output logic                   halted_o,
  output logic                   bp_hit_o,
  output logic                   timeout_o,
  output logic [COUNT_WIDTH-1:0] steps_done_o
);

  localparam logic [2:0] CMD_HALT  = 3'd1;
  localparam logic [2:0] CMD_RUN   = 3'd2;
  localparam logic [2:0] CMD_STEP  = 3'd3;
  localparam logic [2:0] CMD_DSTEP = 3'd4;
  localparam logic [2:0] CMD_CLR   = 3'd5;
  localparam logic [2:0] CMD_ILL6  = 3'd6;
  localparam logic [2:0] CMD_ILL7  = 3'd7;

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_RUNNING,
    ST_HALTING,
    ST_HALTED,
    ST_REQ,
    ST_REL
  } state_t;

  localparam state_t RESET_STATE = RESET_HALTED ? ST_HALTING : ST_RUNNING;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] steps_q, steps_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   mode_q, mode_d;
  logic                   bp_hit_q, bp_hit_d;
  logic                   bp_pend_q, bp_pend_d;
  logic                   timeout_q, timeout_d;
  logic                   cmd_err_q, cmd_err_d;

  logic accept;
  logic bp_match;

  assign host_cmd_ready_o = (state_q == ST_RUNNING) || (state_q == ST_HALTED);
  assign accept           = host_cmd_valid_i && host_cmd_ready_o;
  assign bp_match         = bp_en_i && fetch_i && (pc_i == bp_addr_i);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    steps_d   = steps_q;
    tmo_d     = tmo_q;
    mode_d    = mode_q;
    bp_hit_d  = bp_hit_q;
    bp_pend_d = bp_pend_q;
    timeout_d = timeout_q;
    cmd_err_d = 1'b0;

    case (state_q)
      ST_RUNNING: begin
        if (bp_match) begin
          bp_hit_d  = 1'b1;
          state_d   = ST_HALTING;
          cmd_err_d = accept;
        end else if (accept) begin
          case (host_cmd_i)
            CMD_HALT: state_d = ST_HALTING;
            CMD_CLR: begin
              bp_hit_d  = 1'b0;
              timeout_d = 1'b0;
            end
            CMD_STEP, CMD_DSTEP, CMD_ILL6, CMD_ILL7: cmd_err_d = 1'b1;
            default: ;
          endcase
        end
      end

      ST_HALTING: begin
        if (stopped_i) state_d = ST_HALTED;
      end

      ST_HALTED: begin
        if (accept) begin
          case (host_cmd_i)
            CMD_RUN: state_d = ST_RUNNING;
            CMD_STEP: begin
              if (host_count_i == '0) begin
                cmd_err_d = 1'b1;
              end else begin
                count_d   = host_count_i;
                steps_d   = '0;
                mode_d    = 1'b0;
                bp_pend_d = 1'b0;
                tmo_d     = TMO_LOAD;
                state_d   = ST_REQ;
              end
            end
            CMD_DSTEP: begin
              count_d   = COUNT_WIDTH'(1);
              steps_d   = '0;
              mode_d    = 1'b1;
              bp_pend_d = 1'b0;
              tmo_d     = TMO_LOAD;
              state_d   = ST_REQ;
            end
            CMD_CLR: begin
              bp_hit_d  = 1'b0;
              timeout_d = 1'b0;
            end
            CMD_ILL6, CMD_ILL7: cmd_err_d = 1'b1;
            default: ;
          endcase
        end
      end

      ST_REQ: begin
        // A breakpoint seen mid-step lets this handshake finish, then ends the command.
        if (bp_match) begin
          bp_hit_d  = 1'b1;
          bp_pend_d = 1'b1;
        end
        if (debug_step_ack_i) begin
          tmo_d   = TMO_LOAD;
          state_d = ST_REL;
        end else if (tmo_q == '0) begin
          timeout_d = 1'b1;
          mode_d    = 1'b0;
          state_d   = ST_HALTED;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end

      ST_REL: begin
        if (!debug_step_ack_i) begin
          if (steps_q != '1) steps_d = steps_q + 1'b1;
          count_d = count_q - 1'b1;
          if (count_q == COUNT_WIDTH'(1) || bp_pend_q) begin
            mode_d  = 1'b0;
            state_d = ST_HALTED;
          end else begin
            tmo_d   = TMO_LOAD;
            state_d = ST_REQ;
          end
        end else if (tmo_q == '0) begin
          timeout_d = 1'b1;
          mode_d    = 1'b0;
          state_d   = ST_HALTED;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end

      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= RESET_STATE;
      count_q   <= '0;
      steps_q   <= '0;
      tmo_q     <= '0;
      mode_q    <= 1'b0;
      bp_hit_q  <= 1'b0;
      bp_pend_q <= 1'b0;
      timeout_q <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      steps_q   <= steps_d;
      tmo_q     <= tmo_d;
      mode_q    <= mode_d;
      bp_hit_q  <= bp_hit_d;
      bp_pend_q <= bp_pend_d;
      timeout_q <= timeout_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign debug_stop_o     = (state_q != ST_RUNNING);
  assign debug_mode_o     = mode_q;
  assign debug_step_req_o = (state_q == ST_REQ);
  assign halted_o         = (state_q == ST_HALTED);
  assign bp_hit_o         = bp_hit_q;
  assign timeout_o        = timeout_q;
  assign cmd_err_o        = cmd_err_q;
  assign steps_done_o     = steps_q;

endmodule

// File: doc/debug_step_controller.md
Name: debug_step_controller

Overview:
Host-facing debug sequencer that sits directly upstream of the instruction phase decoder. It converts host commands into the decoder's DEBUG_STOP / DEBUG_MODE / DEBUG_STEP_REQ controls and runs the four-phase step handshake with DEBUG_STEP_ACK. It adds N-instruction stepping, a single PC breakpoint and an ACK timeout guard.

Parameters:
PC_WIDTH, 16, width of PC and BP_ADDR
COUNT_WIDTH, 16, width of HOST_COUNT and STEPS_DONE
ACK_TIMEOUT, 64, max cycles to wait on any DEBUG_STEP_ACK edge; must be >= 8
RESET_HALTED, 0, 1 = come out of reset in HALTING with DEBUG_STOP high

Ports:
CLK  in  1  system clock; all state changes on rising edge
RESET  in  1  asynchronous, active-low reset
HOST_CMD_VALID  in  1  command strobe
HOST_CMD  in  3  0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 DSTEP, 5 CLR_FLAGS; 6-7 illegal
HOST_COUNT  in  COUNT_WIDTH  step count for STEP; ignored otherwise
HOST_CMD_READY  out  1  command may be accepted this cycle
CMD_ERR  out  1  one-cycle pulse: illegal or rejected command
PC  in  PC_WIDTH  current program counter
BP_ADDR  in  PC_WIDTH  breakpoint address
BP_EN  in  1  breakpoint enable
FETCH  in  1  decoder FETCH phase
STOPPED  in  1  decoder STOPPED phase
DEBUG_STEP_ACK  in  1  decoder step acknowledge
DEBUG_STOP  out  1  to decoder
DEBUG_MODE  out  1  to decoder; 1 during DSTEP only
DEBUG_STEP_REQ  out  1  to decoder
HALTED  out  1  controller is in HALTED state
BP_HIT  out  1  sticky: breakpoint caused the halt
TIMEOUT  out  1  sticky: ACK timeout occurred
STEPS_DONE  out  COUNT_WIDTH  steps completed in the current STEP command

Behaviour:
- Reset (RESET low, async): DEBUG_STOP=RESET_HALTED, DEBUG_MODE=0, DEBUG_STEP_REQ=0, BP_HIT=0, TIMEOUT=0, STEPS_DONE=0, CMD_ERR=0, HALTED=0. State is RUNNING, or HALTING if RESET_HALTED=1. Reset asserted mid-handshake drops REQ immediately.
- Command accept: a command is taken when HOST_CMD_VALID && HOST_CMD_READY at a rising edge. READY=1 only in RUNNING and HALTED.
- States:
  - RUNNING: DEBUG_STOP=0.
    - HALT -> HALTING.
    - Breakpoint: BP_EN && FETCH && PC==BP_ADDR -> BP_HIT=1, go to HALTING. A breakpoint has priority over a command in the same cycle; that command is dropped and CMD_ERR pulses.
    - STEP/DSTEP/illegal -> CMD_ERR. RUN and NOP have no effect.
  - HALTING: DEBUG_STOP=1. Wait for STOPPED=1, then go to HALTED. The decoder finishes the current instruction first, so arrival is within 5 cycles. No timeout applies here.
  - HALTED: DEBUG_STOP=1, HALTED=1.
    - RUN -> RUNNING (DEBUG_STOP=0 next cycle).
    - STEP with HOST_COUNT=0 -> CMD_ERR.
    - STEP with HOST_COUNT>0 -> latch count, STEPS_DONE=0, DEBUG_MODE=0, go to REQ.
    - DSTEP -> count=1, DEBUG_MODE=1, go to REQ.
    - HALT and NOP have no effect. Illegal -> CMD_ERR.
  - REQ: DEBUG_STEP_REQ=1. Wait for ACK=1, then go to REL.
  - REL: DEBUG_STEP_REQ=0. Wait for ACK=0, then STEPS_DONE+=1 and count-=1. If count==0 go to HALTED and clear DEBUG_MODE; otherwise go to REQ.
- Breakpoints are checked during STEP too: if a match occurs during FETCH while in REQ, set BP_HIT=1 and end the command after the current handshake completes (remaining count discarded).
- Timeout: a counter clears on entry to REQ or REL. If it reaches ACK_TIMEOUT cycles: TIMEOUT=1, REQ=0, DEBUG_MODE=0, go to HALTED.
- CLR_FLAGS (RUNNING or HALTED): clears BP_HIT and TIMEOUT. A breakpoint match in the same cycle wins, leaving BP_HIT=1.
- STEPS_DONE saturates at all-ones and holds its value until the next STEP/DSTEP.
- CMD_ERR is a registered pulse, exactly one cycle after the offending accept edge.
- DEBUG_STOP stays 1 throughout HALTED, REQ and REL.

Test Plan:
- Reset with RESET_HALTED=0, then HALT in RUNNING -> DEBUG_STOP=1 next cycle; HALTED=1 within 5 cycles of STOPPED rising; READY=1.
- HALTED, STEP with HOST_COUNT=3 -> three REQ/ACK four-phase handshakes with DEBUG_MODE=0; STEPS_DONE=3; HALTED=1; REQ never high while ACK is still high from the prior step.
- HALTED, DSTEP -> DEBUG_MODE=1 during the handshake, 0 after; STEPS_DONE=1. Then RUN -> DEBUG_STOP=0 and the decoder resumes FETCH.
- RUNNING, BP_EN=1, BP_ADDR=0x0010, PC reaches 0x0010 during FETCH -> BP_HIT=1, HALTING then HALTED. CLR_FLAGS -> BP_HIT=0.
- HALTED, STEP with HOST_COUNT=1 and ACK held at 0 -> after 64 cycles TIMEOUT=1, REQ=0, HALTED=1.
- Error cases -> CMD_ERR pulses once each, with no state change:
  - STEP with HOST_COUNT=0 while HALTED.
  - HOST_CMD=7.
  - STEP while RUNNING.
